// File: rtl/bcd_to_binary.sv
// Serial BCD-to-binary converter: one digit per clock, MSD first, acc = acc*10 + digit.
// Optional invalid-digit detection on err is enabled by defining BCD_CHECK_EN.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned      CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, stateNext;
  logic [4*DIGITS-1:0] shiftReg, shiftNext;
  logic [BIN_W-1:0]    acc, accNext, binReg, binNext, accStep;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic                doneReg, doneNext;
  logic [3:0]          digit;
  logic                lastDigit;

  assign digit     = shiftReg[4*DIGITS-1 -: 4];
  // x10 as shift-add, wrapping modulo 2^BIN_W when BIN_W is undersized
  assign accStep   = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign lastDigit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shiftReg <= '0;
      acc      <= '0;
      cnt      <= '0;
      binReg   <= '0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      acc      <= accNext;
      cnt      <= cntNext;
      binReg   <= binNext;
      doneReg  <= doneNext;
    end
  end

  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    accNext   = acc;
    cntNext   = cnt;
    binNext   = binReg;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shiftNext = bcd_in;
          accNext   = '0;
          cntNext   = '0;
          stateNext = CONV;
        end
      end
      CONV: begin
        accNext   = accStep;
        shiftNext = shiftReg << 4;
        cntNext   = cnt + 1'b1;
        if (lastDigit) begin
          binNext   = accStep;
          doneNext  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign ready   = (state == IDLE);
  assign busy    = (state == CONV);
  assign done    = doneReg;
  assign bin_out = binReg;

`ifdef BCD_CHECK_EN
  logic errFlag, errFlagNext, errReg, errNext, digitBad;

  assign digitBad = (digit > 4'd9);

  // Sticky flag includes the digit consumed on the completion edge itself
  always_comb begin
    errFlagNext = errFlag;
    errNext     = errReg;
    if (state == IDLE) begin
      if (start) errFlagNext = 1'b0;
    end else begin
      errFlagNext = errFlag | digitBad;
      if (lastDigit) errNext = errFlag | digitBad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errFlag <= 1'b0;
      errReg  <= 1'b0;
    end else begin
      errFlag <= errFlagNext;
      errReg  <= errNext;
    end
  end

  assign err = errReg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary; drives a BIN_W=14 and a BIN_W=10 instance in lockstep.
module tb_bcd_to_binary;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;

  logic        ready, busy, done, err;
  logic [13:0] bin_out;
  logic        ready10, busy10, done10, err10;
  logic [9:0]  bin10;

  int nChecks = 0;
  int nFail   = 0;

`ifdef BCD_CHECK_EN
  localparam logic ERR_BAD = 1'b1;
`else
  localparam logic ERR_BAD = 1'b0;
`endif

  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .ready(ready), .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  bcd_to_binary #(.DIGITS(4), .BIN_W(10)) dut10 (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .ready(ready10), .busy(busy10), .done(done10), .bin_out(bin10), .err(err10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full conversion: accept, three quiet cycles, then the done cycle.
  task automatic runConv(input string tag, input logic [15:0] bcd,
                         input logic [31:0] exp14, input logic [31:0] exp10,
                         input logic expErr);
    bcd_in = bcd;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({tag, " busy after accept"}, busy, 1);
    chk({tag, " ready after accept"}, ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, " done early"}, done, 0);
    end
    tick();
    chk({tag, " done"}, done, 1);
    chk({tag, " done10"}, done10, 1);
    chk({tag, " bin_out"}, bin_out, exp14);
    chk({tag, " bin10"}, bin10, exp10);
    chk({tag, " err"}, err, expErr);
    chk({tag, " ready in done"}, ready, 1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    tick();
    tick();
    chk("reset ready", ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bin_out", bin_out, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    tick();

    // Basic conversion and hold after completion
    runConv("c1234", 16'h1234, 1234, 210, 1'b0);
    tick();
    chk("c1234 done pulse width", done, 0);
    chk("c1234 bin_out held", bin_out, 1234);

    // Back-to-back: start held through CONV and into the done cycle
    bcd_in = 16'h9999;
    start  = 1'b1;
    tick();
    bcd_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b first done early", done, 0);
    end
    tick();
    chk("b2b first done", done, 1);
    chk("b2b first bin_out", bin_out, 9999);
    chk("b2b first bin10", bin10, 783);
    tick();
    start = 1'b0;
    chk("b2b second accepted", busy, 1);
    chk("b2b done cleared", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b second done early", done, 0);
    end
    tick();
    chk("b2b second done", done, 1);
    chk("b2b second bin_out", bin_out, 0);

    // Start requests during CONV are dropped
    tick();
    bcd_in = 16'h0042;
    start  = 1'b1;
    tick();
    bcd_in = 16'h7777;
    tick();
    tick();
    tick();
    start = 1'b0;
    chk("ignore no early done", done, 0);
    tick();
    chk("ignore done", done, 1);
    chk("ignore bin_out", bin_out, 42);
    tick();
    chk("ignore idle after", busy, 0);
    chk("ignore ready after", ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ignore no second done", done, 0);
    end

    // Reset mid-conversion abandons the job
    bcd_in = 16'h5678;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst ready", ready, 1);
    chk("midrst bin_out", bin_out, 0);
    chk("midrst done", done, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst no done", done, 0);
    end
    runConv("c0001", 16'h0001, 1, 1, 1'b0);
    tick();

    // Non-decimal nibble: raw value used, err only with the check built in
    runConv("c12A4", 16'h12A4, 1304, 280, ERR_BAD);
    tick();
    chk("c12A4 err held", err, ERR_BAD);
    chk("c12A4 bin_out held", bin_out, 1304);
    runConv("c0010", 16'h0010, 10, 10, 1'b0);
    tick();

    // Truncation in the narrow instance
    runConv("c2000", 16'h2000, 2000, 976, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Serial BCD-to-binary converter; the inverse of the team's binary-to-BCD digit-accumulator chain.
- Loads a packed DIGITS-digit BCD word on a start handshake.
- Consumes one decimal digit per clock, most significant digit (MSD) first, using acc = acc*10 + digit.
- Presents the binary result with a one-cycle done pulse. Used wherever decimal display or keypad values must return to binary datapaths.

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (>=1).
- BIN_W, 14, width of bin_out; must hold 10^DIGITS-1 for exact results, otherwise the result is truncated.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request conversion; sampled only when ready=1.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0], MSD in the top nibble; sampled on the accepting edge only.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bin_out valid and updated.
- bin_out  output  BIN_W  converted result; held until the next completion.
- err  output  1  invalid-digit flag (see Optional Feature); valid with done.

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- Reset values:
  - state IDLE, ready=1, busy=0, done=0, bin_out=0, err=0.
  - Internal accumulator, digit shift register and digit counter all cleared.
- States: IDLE, CONV.
- IDLE:
  - ready=1, busy=0.
  - On a clock edge with start=1: latch bcd_in into the shift register, clear acc, clear counter, clear the err tracking flag, go to CONV.
- CONV:
  - ready=0, busy=1.
  - Each edge: d = top nibble of the shift register; acc <= acc*10 + d, computed as (acc<<3)+(acc<<1)+d, modulo 2^BIN_W.
  - Shift register shifts left 4; counter increments.
  - On the edge that processes digit index 0 (counter == DIGITS-1): bin_out <= final acc value, done <= 1, err <= accumulated flag, go to IDLE.
- Latency: start sampled at edge T0. Digits are processed at edges T1..T_DIGITS. done is high for exactly the cycle following T_DIGITS. busy is high from after T0 until T_DIGITS. DIGITS=4 gives done 4 cycles after acceptance.
- done is a single-cycle pulse. All other cycles have done=0.
- bin_out and err change only on the completion edge or on reset.
- start while busy: ignored, no queueing, and the in-flight conversion is unaffected.
- start high in the cycle where done=1: accepted, since the state is IDLE. This gives back-to-back conversions with a DIGITS+1 cycle period.
- Holding start continuously gives back-to-back conversions.
- bcd_in changing during CONV has no effect.
- Reset mid-conversion: conversion is abandoned, all outputs go to reset values, and no done pulse is issued.
- Overflow when BIN_W is too small: silent modulo-2^BIN_W truncation, no flag.
- DIGITS=1: CONV lasts one cycle; bin_out = digit.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - Each digit consumed in CONV with value >9 (0xA..0xF) sets a sticky internal flag. The flag is cleared on start acceptance and presented on err with done.
  - The arithmetic still uses the raw nibble value, e.g. 0xA contributes 10.
  - err holds with bin_out until the next completion.
- Not defined: err is constant 0. The check logic is absent. Arithmetic is identical.

Test Plan:
- DIGITS=4, BIN_W=14, reset then start with bcd_in=0x1234 -> done pulses exactly 4 cycles after acceptance for 1 cycle; bin_out=1234 (0x04D2); err=0; ready=1 in the done cycle.
- bcd_in=0x9999 -> bin_out=9999 (0x270F). Then bcd_in=0x0000 -> bin_out=0. Second start is asserted in the done cycle of the first -> accepted, no idle gap.
- Start 0x0042, then pulse start with bcd_in=0x7777 at cycles 1-3 of CONV -> single done, bin_out=42, the 0x7777 request is dropped.
- Start 0x5678, assert rst at cycle 2 of CONV -> next cycle busy=0, ready=1, bin_out=0, done never pulses. New start 0x0001 -> bin_out=1.
- With BCD_CHECK_EN: bcd_in=0x12A4 -> bin_out=1304, err=1. A following 0x0010 -> bin_out=10, err=0. Without the macro: same bin_out, err always 0.
- DIGITS=4, BIN_W=10: bcd_in=0x2000 -> bin_out=2000 mod 1024=976, done timing unchanged.
